// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential multiplier.
// State encoding and per-iteration digit size.
package mult_seq_pkg;

  localparam int DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_nx4.sv
// Combinational WIDTH x 4 unsigned partial-product unit.
// Result is WIDTH+4 bits, so it never overflows.
module mult_nx4 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [3:0]       d,
  output logic [WIDTH+3:0] pp
);

  assign pp = {4'b0, a} * {{WIDTH{1'b0}}, d};

endmodule

// File: rtl/mult_seq.sv
// Sequential radix-16 multiplier, signed or unsigned.
// Sign-magnitude datapath; one B digit per cycle.
module mult_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = mult_seq_pkg::DIGIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);
  import mult_seq_pkg::*;

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   amag, bsh;
  logic               neg;
  logic [2*WIDTH-1:0] acc, acc_nxt, ppx;
  logic [CW-1:0]      cnt;
  logic [WIDTH+3:0]   pp;
  logic               last, accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_neg = is_signed & a[WIDTH-1];
  assign b_neg = is_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign last   = (cnt == CW'(N - 1));
  assign accept = in_valid & in_ready;

  mult_nx4 #(.WIDTH(WIDTH)) u_pp (
    .a  (amag),
    .d  (bsh[3:0]),
    .pp (pp)
  );

  assign ppx     = {{(WIDTH-4){1'b0}}, pp} << {cnt, 2'b00};
  assign acc_nxt = acc + ppx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, digit accumulation and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      amag <= '0;
      bsh  <= '0;
      neg  <= 1'b0;
      acc  <= '0;
      cnt  <= '0;
      p    <= '0;
    end else if (accept) begin
      amag <= a_mag;
      bsh  <= b_mag;
      neg  <= a_neg ^ b_neg;
      acc  <= '0;
      cnt  <= '0;
    end else if (state == RUN) begin
      acc <= acc_nxt;
      bsh <= bsh >> DIGIT;
      cnt <= cnt + 1'b1;
      if (last) p <= neg ? -acc_nxt : acc_nxt;
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed and random checks of mult_seq at WIDTH 16 and 8.
// Expected products come from a queue filled at acceptance.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv16, ir16, s16, ov16, or16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  logic        iv8, ir8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic [31:0] q16[$];
  logic [15:0] q8[$];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(iv16), .in_ready(ir16),
    .a(a16), .b(b16), .is_signed(s16),
    .out_valid(ov16), .out_ready(or16), .p(p16)
  );

  mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .a(a8), .b(b8), .is_signed(s8),
    .out_valid(ov8), .out_ready(or8), .p(p8)
  );

  function automatic logic [31:0] ref16(
    input logic [15:0] x, input logic [15:0] y, input logic s);
    longint r;
    if (s) r = longint'($signed(x)) * longint'($signed(y));
    else   r = longint'(x) * longint'(y);
    return r[31:0];
  endfunction

  function automatic logic [15:0] ref8(
    input logic [7:0] x, input logic [7:0] y, input logic s);
    longint r;
    if (s) r = longint'($signed(x)) * longint'($signed(y));
    else   r = longint'(x) * longint'(y);
    return r[15:0];
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic xact16(input logic [15:0] av, input logic [15:0] bv,
                        input logic s, input int hold);
    int lat;
    logic [31:0] e;
    @(posedge clk); #1;
    a16 = av; b16 = bv; s16 = s; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    q16.push_back(ref16(av, bv, s));
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat16", 64'(lat), 64'd4);
    e = (q16.size() > 0) ? q16.pop_front() : 32'hx;
    chk("p16", 64'(p16), 64'(e));
    for (int i = 0; i < hold; i++) begin
      iv16 = 1'b1; a16 = 16'h0101; b16 = 16'h0202;
      @(posedge clk); #1;
      chk("hold_p", 64'(p16), 64'(e));
      chk("hold_ov", 64'(ov16), 64'd1);
      chk("hold_ir", 64'(ir16), 64'd0);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("idle_ir", 64'(ir16), 64'd1);
    chk("idle_ov", 64'(ov16), 64'd0);
    chk("kept_p", 64'(p16), 64'(e));
  endtask

  task automatic xact8(input logic [7:0] av, input logic [7:0] bv,
                       input logic s);
    int lat;
    logic [15:0] e;
    @(posedge clk); #1;
    a8 = av; b8 = bv; s8 = s; iv8 = 1'b1;
    @(posedge clk); #1;
    iv8 = 1'b0;
    q8.push_back(ref8(av, bv, s));
    lat = 0;
    while (!ov8 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = (q8.size() > 0) ? q8.pop_front() : 16'hx;
    chk("p8", {32'(lat), 16'h0, p8}, {32'd2, 16'h0, e});
  endtask

  logic [7:0] corner [8];

  initial begin
    corner[0] = 8'h00; corner[1] = 8'h01;
    corner[2] = 8'h7F; corner[3] = 8'h80;
    corner[4] = 8'h81; corner[5] = 8'hFF;
    corner[6] = 8'h55; corner[7] = 8'hAA;

    rst = 1'b1;
    iv16 = 0; a16 = 0; b16 = 0; s16 = 0; or16 = 0;
    iv8 = 0; a8 = 0; b8 = 0; s8 = 0; or8 = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ir", 64'(ir16), 64'd1);
    chk("rst_ov", 64'(ov16), 64'd0);
    chk("rst_p", 64'(p16), 64'd0);
    chk("rst_ir8", 64'(ir8), 64'd1);

    xact16(16'hFFFF, 16'hFFFF, 1'b0, 5);
    chk("ffff_u", 64'(p16), 64'hFFFE0001);
    xact16(16'h8000, 16'h8000, 1'b1, 0);
    chk("8000_s", 64'(p16), 64'h40000000);
    xact16(16'hFFFF, 16'h0003, 1'b1, 0);
    chk("m1x3_s", 64'(p16), 64'hFFFFFFFD);
    xact16(16'hFFFF, 16'h0003, 1'b0, 0);
    chk("m1x3_u", 64'(p16), 64'h0002FFFD);
    xact16(16'h0000, 16'h1234, 1'b0, 0);
    xact16(16'h7FFF, 16'h8000, 1'b1, 1);
    xact16(16'h1234, 16'h0000, 1'b1, 0);

    @(posedge clk); #1;
    a16 = 16'h1234; b16 = 16'h5678; s16 = 0; iv16 = 1;
    @(posedge clk); #1;
    iv16 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; iv16 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; iv16 = 1'b0;
    chk("mid_ir", 64'(ir16), 64'd1);
    chk("mid_ov", 64'(ov16), 64'd0);
    chk("mid_p", 64'(p16), 64'd0);
    repeat (6) begin
      @(posedge clk); #1;
      chk("mid_no_out", 64'(ov16), 64'd0);
    end
    xact16(16'd7, 16'd6, 1'b0, 0);
    chk("7x6", 64'(p16), 64'd42);

    for (int i = 0; i < 40; i++)
      xact16(16'($urandom), 16'($urandom), 1'($urandom), 0);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        xact8(corner[i], corner[j], 1'b0);
        xact8(corner[i], corner[j], 1'b1);
      end
    for (int i = 0; i < 300; i++)
      xact8(8'($urandom), 8'($urandom), 1'($urandom));

    chk("q16_empty", 64'(q16.size()), 64'd0);
    chk("q8_empty", 64'(q8.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
